// File: rtl/spi_reg_ctrl_pkg.sv
// Shared state encoding, command-byte layout and constants for the SPI
// command/register controller.
package spi_reg_ctrl_pkg;

    localparam int                ADDR_W      = 7;
    localparam int                CMD_RD_BIT  = 7;
    localparam logic [ADDR_W-1:0] ERRCNT_ADDR = 7'h7F;
    localparam logic [7:0]        DEF_ID_BYTE = 8'hA5;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD_LOAD,
        ST_RD_WAIT
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_cs_sync.sv
// Two-flop synchronizer for the raw chip select with single-cycle
// falling (frame start) and rising (frame end) pulses.
module spi_cs_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n_i,
    output logic cs_n_sync_o,
    output logic fall_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= cs_n_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign cs_n_sync_o = sync_q;
    assign fall_o      = prev_q & ~sync_q;
    assign rise_o      = ~prev_q & sync_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller on the user side of SPI_SLAVE.
// Optional saturating error counter at 7'h7F: define SPI_REG_CTRL_ERRCNT_EN.
module spi_reg_ctrl
    import spi_reg_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 8,
    parameter logic [7:0]  REG_RESET = 8'hFF,
    parameter logic [7:0]  ID_BYTE   = DEF_ID_BYTE
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CS_N,
    output logic [7:0]            SPI_DIN,
    output logic                  SPI_DIN_VLD,
    input  logic                  SPI_READY,
    input  logic [7:0]            SPI_DOUT,
    input  logic                  SPI_DOUT_VLD,
    output logic [NUM_REGS*8-1:0] REGS,
    output logic [NUM_REGS-1:0]   WR_STB,
    output logic                  BUSY
);

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

    state_e              state_q, state_d;
    addr_t               addr_q, addr_d;
    logic [7:0]          din_q, din_d;
    logic                din_vld_q, din_vld_d;
    logic [7:0]          regs_q [NUM_REGS];
    logic [7:0]          regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;

    logic                cs_n_sync;
    logic                cs_fall;
    logic                cs_rise;
    logic                accept;
    logic                addr_in_range;
    logic [7:0]          rd_data;

    spi_cs_sync u_cs_sync (
        .clk         (CLK),
        .rst_n       (RST_N),
        .cs_n_i      (CS_N),
        .cs_n_sync_o (cs_n_sync),
        .fall_o      (cs_fall),
        .rise_o      (cs_rise)
    );

    assign accept        = SPI_READY & din_vld_q;
    assign addr_in_range = ({1'b0, addr_q} < NUM_REGS_L);

`ifdef SPI_REG_CTRL_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;
    logic       addr_is_errcnt;

    assign addr_is_errcnt = (addr_q == ERRCNT_ADDR);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) errcnt_q <= 8'h00;
        else        errcnt_q <= errcnt_d;
    end
`endif

    // Out-of-range addresses read as zero unless they hit the error counter.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == addr_t'(i)) rd_data = regs_q[i];
        end
`ifdef SPI_REG_CTRL_ERRCNT_EN
        if (addr_is_errcnt) rd_data = errcnt_q;
`endif
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and synthesis never has to infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        din_d     = din_q;
        din_vld_d = din_vld_q;
        regs_d    = regs_q;
        wr_stb_d  = '0;
`ifdef SPI_REG_CTRL_ERRCNT_EN
        errcnt_d  = errcnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                din_d     = ID_BYTE;
                din_vld_d = 1'b1;
                if (cs_fall) state_d = ST_CMD;
            end

            ST_CMD: begin
                if (accept) din_vld_d = 1'b0;
                if (SPI_DOUT_VLD) begin
                    addr_d  = SPI_DOUT[ADDR_W-1:0];
                    state_d = SPI_DOUT[CMD_RD_BIT] ? ST_RD_LOAD : ST_WR;
                end
            end

            ST_WR: begin
                if (accept) din_vld_d = 1'b0;
                if (SPI_DOUT_VLD) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == addr_t'(i)) begin
                            regs_d[i]   = SPI_DOUT;
                            wr_stb_d[i] = 1'b1;
                        end
                    end
`ifdef SPI_REG_CTRL_ERRCNT_EN
                    if (addr_is_errcnt)     errcnt_d = 8'h00;
                    else if (!addr_in_range) errcnt_d = sat_inc8(errcnt_q);
`endif
                    addr_d = addr_q + 1'b1;
                end
            end

            ST_RD_LOAD: begin
                din_d     = rd_data;
                din_vld_d = 1'b1;
                state_d   = ST_RD_WAIT;
`ifdef SPI_REG_CTRL_ERRCNT_EN
                if (!addr_in_range && !addr_is_errcnt) errcnt_d = sat_inc8(errcnt_q);
`endif
            end

            ST_RD_WAIT: begin
                if (accept) begin
                    din_vld_d = 1'b0;
                    addr_d    = addr_q + 1'b1;
                    state_d   = ST_RD_LOAD;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Frame end wins over everything except a byte landing the same cycle,
        // which has already been committed above.
        if (cs_rise) begin
            state_d   = ST_IDLE;
            din_vld_d = 1'b0;
            din_d     = ID_BYTE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            din_q     <= ID_BYTE;
            din_vld_q <= 1'b0;
            wr_stb_q  <= '0;
            // NOTE: this bank is board-visible state with a defined power-up
            // value, so it is reset like any flop rather than left as RAM.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            din_vld_q <= din_vld_d;
            wr_stb_q  <= wr_stb_d;
            regs_q    <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign REGS[8*g +: 8] = regs_q[g];
    end

    assign SPI_DIN     = din_q;
    assign SPI_DIN_VLD = din_vld_q;
    assign WR_STB      = wr_stb_q;
    assign BUSY        = ~cs_n_sync;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: an SPI_SLAVE stand-in drives frames,
// a behavioural register model predicts MISO bytes and register writes.
module tb_spi_reg_ctrl;

    localparam int         NR = 8;
    localparam logic [7:0] ID = 8'hA5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cs_n;
    logic [7:0]        spi_din;
    logic              spi_din_vld;
    logic              spi_ready;
    logic [7:0]        spi_dout;
    logic              spi_dout_vld;
    logic [NR*8-1:0]   regs;
    logic [NR-1:0]     wr_stb;
    logic              busy;

    always #21 clk = ~clk;

    spi_reg_ctrl #(
        .NUM_REGS  (NR),
        .REG_RESET (8'hFF),
        .ID_BYTE   (ID)
    ) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .CS_N         (cs_n),
        .SPI_DIN      (spi_din),
        .SPI_DIN_VLD  (spi_din_vld),
        .SPI_READY    (spi_ready),
        .SPI_DOUT     (spi_dout),
        .SPI_DOUT_VLD (spi_dout_vld),
        .REGS         (regs),
        .WR_STB       (wr_stb),
        .BUSY         (busy)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];
    logic [15:0] wr_q [$];
    logic [7:0]  mdl [128];
    logic [7:0]  errc;
    logic [7:0]  fb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Register model: plain array plus optional error counter.
    function automatic void mdl_write(input logic [6:0] a, input logic [7:0] d);
        if (int'(a) < NR) begin
            mdl[a] = d;
            wr_q.push_back({1'b0, a, d});
        end
`ifdef SPI_REG_CTRL_ERRCNT_EN
        else if (a == 7'h7F) errc = 8'h00;
        else if (errc != 8'hFF) errc = errc + 8'd1;
`endif
    endfunction

    function automatic logic [7:0] mdl_load(input logic [6:0] a);
        if (int'(a) < NR) return mdl[a];
`ifdef SPI_REG_CTRL_ERRCNT_EN
        if (a == 7'h7F) return errc;
        if (errc != 8'hFF) errc = errc + 8'd1;
`endif
        return 8'h00;
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < 128; i++) mdl[i] = 8'hFF;
        errc = 8'h00;
    endfunction

    // Monitor: every MISO handshake and every write strobe is checked in order.
    logic [7:0]  mon_e;
    logic [15:0] mon_w;
    always @(negedge clk) begin
        if (rst_n && spi_ready && spi_din_vld) begin
            if (exp_q.size() == 0) check("miso_unexpected", 32'(exp_q.size()), 32'd1);
            else begin
                mon_e = exp_q.pop_front();
                check("miso_byte", 32'(spi_din), 32'(mon_e));
            end
        end
        if (wr_stb != '0) begin
            if (wr_q.size() == 0) check("wr_stb_unexpected", 32'(wr_stb), 32'd0);
            else begin
                mon_w = wr_q.pop_front();
                check("wr_stb_onehot", 32'(wr_stb), 32'd1 << mon_w[15:8]);
                check("wr_stb_data", 32'(regs[8*mon_w[15:8] +: 8]), 32'(mon_w[7:0]));
            end
        end
    end

    // mode 0: normal byte, 1: CS_N raised mid-byte, 2: CS_N end coincides with DOUT_VLD.
    task automatic xfer(input logic [7:0] mosi, input bit hs, input logic [7:0] e, input int mode);
        if (hs) begin
            int t = 0;
            while (!spi_din_vld && t < 40) begin
                @(posedge clk); #1;
                t++;
            end
            if (!spi_din_vld) check("din_vld_timeout", 32'(spi_din_vld), 32'd1);
            else begin
                exp_q.push_back(e);
                spi_ready = 1'b1;
                @(posedge clk); #1;
                spi_ready = 1'b0;
            end
        end
        repeat (8) @(posedge clk);
        #1;
        if (mode == 1) begin
            cs_n = 1'b1;
            return;
        end
        if (mode == 2) begin
            cs_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        spi_dout     = mosi;
        spi_dout_vld = 1'b1;
        @(posedge clk); #1;
        spi_dout_vld = 1'b0;
        repeat (7) @(posedge clk);
        #1;
    endtask

    task automatic end_of_frame_checks();
        cs_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("busy_idle", 32'(busy), 32'd0);
        check("idle_din", 32'(spi_din), 32'(ID));
        check("idle_din_vld", 32'(spi_din_vld), 32'd1);
        check("miso_drain", 32'(exp_q.size()), 32'd0);
        check("wr_drain", 32'(wr_q.size()), 32'd0);
        exp_q.delete();
        wr_q.delete();
        for (int i = 0; i < NR; i++)
            check($sformatf("reg%0d", i), 32'(regs[8*i +: 8]), 32'(mdl[i]));
    endtask

    task automatic run_frame(input logic [7:0] b [$], input int abort_at, input bit coincide);
        logic [6:0] a;
        bit         rd;
        logic [7:0] cur;
        cur  = 8'h00;
        cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_frame", 32'(busy), 32'd1);
        rd = b[0][7];
        a  = b[0][6:0];
        for (int k = 0; k < b.size(); k++) begin
            int         mode = (k == abort_at) ? 1 : ((coincide && k == b.size() - 1) ? 2 : 0);
            bit         hs   = (k == 0) || rd;
            logic [7:0] e    = (k == 0) ? ID : cur;
            if (mode != 1 && k > 0 && !rd) begin
                mdl_write(a, b[k]);
                a = a + 7'd1;
            end
            xfer(b[k], hs, e, mode);
            if (k == 0 && rd && mode == 0) cur = mdl_load(a);
            else if (k > 0 && rd) begin
                a   = a + 7'd1;
                cur = mdl_load(a);
            end
            if (mode == 1) break;
        end
        end_of_frame_checks();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        cs_n         = 1'b1;
        spi_ready    = 1'b0;
        spi_dout     = 8'h00;
        spi_dout_vld = 1'b0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_din_vld", 32'(spi_din_vld), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_din", 32'(spi_din), 32'(ID));
        check("post_rst_din_vld", 32'(spi_din_vld), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NR; i++)
            check($sformatf("rst_reg%0d", i), 32'(regs[8*i +: 8]), 32'hFF);

        fb = {8'h01, 8'h3C, 8'h5A};        run_frame(fb, -1, 1'b0);
        fb = {8'h81, 8'h00, 8'h00};        run_frame(fb, -1, 1'b0);
        fb = {8'h07, 8'h11, 8'h22};        run_frame(fb, -1, 1'b0);
        fb = {8'hFF, 8'h00};               run_frame(fb, -1, 1'b0);
        fb = {8'h7E, 8'h33, 8'h44, 8'h55}; run_frame(fb, -1, 1'b0);
        fb = {8'h03, 8'h99};               run_frame(fb, 1, 1'b0);
        fb = {8'h80, 8'h00};               run_frame(fb, -1, 1'b0);
        fb = {8'h04, 8'h77};               run_frame(fb, -1, 1'b1);
        fb = {8'h84, 8'h00, 8'h00};        run_frame(fb, -1, 1'b0);

        for (int f = 0; f < 30; f++) begin
            logic [6:0] addr;
            int         sel   = int'($urandom_range(0, 7));
            int         n     = int'($urandom_range(1, 4));
            int         abort = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n)) : -1;
            bit         coin  = ($urandom_range(0, 7) == 0);
            addr = (sel == 0) ? 7'h7F : (sel == 1) ? 7'h7E : 7'($urandom_range(0, NR + 1));
            fb.delete();
            fb.push_back({1'($urandom_range(0, 1)), addr});
            for (int j = 0; j < n; j++) fb.push_back(8'($urandom));
            run_frame(fb, abort, coin);
        end

        // Reset while a read byte is waiting for acceptance.
        cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        xfer(8'h82, 1'b1, ID, 0);
        check("rd_wait_din_vld", 32'(spi_din_vld), 32'd1);
        check("rd_wait_din", 32'(spi_din), 32'(mdl_load(7'd2)));
        rst_n = 1'b0;
        #1;
        check("midrst_din_vld", 32'(spi_din_vld), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wr_stb", 32'(wr_stb), 32'd0);
        for (int i = 0; i < NR; i++)
            check($sformatf("midrst_reg%0d", i), 32'(regs[8*i +: 8]), 32'hFF);
        mdl_reset();
        exp_q.delete();
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rerst_din", 32'(spi_din), 32'(ID));
        check("rerst_din_vld", 32'(spi_din_vld), 32'd1);
        fb = {8'h80, 8'h00, 8'h00};        run_frame(fb, -1, 1'b0);
        fb = {8'h05, 8'hC3};               run_frame(fb, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Command/register controller sitting on the user side of the SPI_SLAVE byte interface. It sequences each chip-select frame: decodes the command byte, auto-increments an address, commits write bytes into a local register bank, and feeds read data back through the DIN/DIN_VLD/READY handshake. The register bank drives board outputs (reg 0 -> leds) in place of the direct echo path in the top level.

Parameters:
NUM_REGS, 8, number of 8-bit registers (1..127), addresses 0..NUM_REGS-1
REG_RESET, 8'hFF, reset value of every register
ID_BYTE, 8'hA5, byte returned on MISO during the command byte

Ports:
CLK  input  1  system clock (24 MHz)
RST_N  input  1  reset; one clock; reset is asynchronous and active-low
CS_N  input  1  raw SPI chip select (asynchronous), synchronized internally
SPI_DIN  output  8  data to SPI_SLAVE DIN
SPI_DIN_VLD  output  1  to SPI_SLAVE DIN_VLD
SPI_READY  input  1  from SPI_SLAVE READY
SPI_DOUT  input  8  from SPI_SLAVE DOUT
SPI_DOUT_VLD  input  1  from SPI_SLAVE DOUT_VLD, 1-cycle pulse per received byte
REGS  output  NUM_REGS*8  flattened register bank, reg i at [8i+7:8i]
WR_STB  output  NUM_REGS  1-cycle pulse on bit i when reg i is written
BUSY  output  1  high while a frame is active (synchronized CS_N low)

Behaviour:
- Reset: REGS all REG_RESET, WR_STB 0, SPI_DIN ID_BYTE, SPI_DIN_VLD 0, BUSY 0, addr 0, state IDLE.
- CS_N: 2-FF synchronizer; frame start = sync falling edge, frame end = sync rising edge. CS_N latency 2-3 CLK.
- Command byte: bit7 = 1 read / 0 write; bits[6:0] = start address.
- States:
  IDLE: SPI_DIN=ID_BYTE, SPI_DIN_VLD=1 (registered, set 1 cycle after entry). Frame start -> CMD.
  CMD: SPI_DIN_VLD cleared on SPI_READY&SPI_DIN_VLD. On SPI_DOUT_VLD: addr<=SPI_DOUT[6:0]; bit7 ? RD_LOAD : WR.
  WR: each SPI_DOUT_VLD: if addr<NUM_REGS, reg[addr]<=SPI_DOUT and WR_STB[addr] pulses the same cycle the register updates (1 cycle after DOUT_VLD); else write dropped. addr<=addr+1 either way.
  RD_LOAD: SPI_DIN<=reg[addr] (8'h00 if addr>=NUM_REGS), SPI_DIN_VLD<=1 -> RD_WAIT. One cycle.
  RD_WAIT: on SPI_READY&SPI_DIN_VLD: SPI_DIN_VLD<=0, addr<=addr+1 -> RD_LOAD. SPI_DOUT_VLD (dummy bytes) ignored.
- Any state, frame end -> IDLE next cycle; registers retained; pending SPI_DIN_VLD dropped, then reloaded with ID_BYTE.
- Frame end and SPI_DOUT_VLD same cycle: the byte is processed (write commits), then IDLE.
- Address is 7-bit, wraps 7'h7F -> 7'h00.
- Handshake: SPI_DIN/SPI_DIN_VLD stable until accepted; never change SPI_DIN while SPI_DIN_VLD=1 and READY=0.
- Timing contract: master idles at least 6 CLK between bytes so RD_LOAD completes before the next shift. Read data for addr N appears in the byte after the command byte.
- Reset mid-frame: immediate return to reset values; the frame is abandoned, and the controller waits for the next falling edge.

Optional Feature:
SPI_REG_CTRL_ERRCNT_EN: adds an 8-bit saturating error counter. It increments on every out-of-range write or read (addr>=NUM_REGS, excluding 7'h7F). The counter reads at address 7'h7F and a write there clears it; it resets to 0. Without the macro, 7'h7F is an ordinary out-of-range address: it reads 8'h00 and writes are dropped.

Decomposition:
- Package spi_reg_ctrl_pkg: state encoding (IDLE, CMD, WR, RD_LOAD, RD_WAIT), CMD_RD_BIT=7, ADDR_W=7, ERRCNT_ADDR=7'h7F, default ID_BYTE.
- Sub-module spi_cs_sync: 2-FF synchronizer plus rise/fall pulse outputs, async active-low reset to synced-high.

Test Plan:
- Reset release, no frame -> REGS all 8'hFF, SPI_DIN=8'hA5, SPI_DIN_VLD=1 within 2 CLK, BUSY=0.
- Frame {8'h01, 8'h3C, 8'h5A} -> reg1=8'h3C, reg2=8'h5A, WR_STB[1] then WR_STB[2] single pulses; MISO byte0 = 8'hA5.
- Frame {8'h81, dummy, dummy} after the previous test -> MISO bytes 8'hA5, 8'h3C, 8'h5A.
- Write frame {8'h07, 8'h11, 8'h22} with NUM_REGS=8 -> reg7=8'h11, addr 8 dropped, no WR_STB for it; with ERRCNT_EN, read of 7'h7F returns 8'h01.
- CS_N raised mid-byte during a write, then new frame {8'h80, dummy} -> no partial write; MISO returns reg0, FSM back in IDLE between frames.
- Assert RST_N low during RD_WAIT -> SPI_DIN_VLD=0 and REGS=8'hFF immediately; next frame decodes normally.
